ctrl_sequencer: RTL

Parametrised, registered successor to the pipeline decode/control unit. Each valid opcode is decoded into registered datapath control fields. Multi-step opcodes run as a micro-sequence: the block asserts `freeze` to hold the fetch/decode stage until the last step. It sits between the ID-stage opcode field and the ID/EX pipeline register, and adds reset, stall-hold, instruction-valid gating and illegal-opcode flagging.

---
 rtl/ctrl_sequencer.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/ctrl_sequencer.sv
// Registered decode/control unit for the ID stage: single-step opcodes map straight to
// datapath controls, while SWP/ROT run as micro-sequences that freeze fetch until the last step.
module ctrl_sequencer #(
   parameter int unsigned           OPCODE_W = 6,
   parameter int unsigned           EXEC_W   = 4,
   parameter int unsigned           STEP_W   = 2,
   parameter logic [OPCODE_W-1:0]   SWP_OPC  = OPCODE_W'(6'b111111),
   parameter logic [OPCODE_W-1:0]   ROT_OPC  = OPCODE_W'(6'b111110)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                valid_in,
   input  logic                stall,
   output logic [EXEC_W-1:0]   exec_cmd,
   output logic                mem_r_en,
   output logic                mem_w_en,
   output logic                wb_en,
   output logic                is_imm,
   output logic                single_src,
   output logic [1:0]          branch_type,
   output logic                is_seq,
   output logic [STEP_W-1:0]   seq_sel,
   output logic [STEP_W-1:0]   step,
   output logic                freeze,
   output logic                illegal,
   output logic                state_dbg
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_SEQ  = 1'b1
   } state_e;

   localparam logic [OPCODE_W-1:0] OP_NOP  = OPCODE_W'(6'b000000);
   localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(6'b000001);
   localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(6'b000011);
   localparam logic [OPCODE_W-1:0] OP_AND  = OPCODE_W'(6'b000101);
   localparam logic [OPCODE_W-1:0] OP_OR   = OPCODE_W'(6'b000110);
   localparam logic [OPCODE_W-1:0] OP_NOR  = OPCODE_W'(6'b000111);
   localparam logic [OPCODE_W-1:0] OP_XOR  = OPCODE_W'(6'b001000);
   localparam logic [OPCODE_W-1:0] OP_SLA  = OPCODE_W'(6'b001001);
   localparam logic [OPCODE_W-1:0] OP_SLL  = OPCODE_W'(6'b001010);
   localparam logic [OPCODE_W-1:0] OP_SRA  = OPCODE_W'(6'b001011);
   localparam logic [OPCODE_W-1:0] OP_SRL  = OPCODE_W'(6'b001100);
   localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'b100000);
   localparam logic [OPCODE_W-1:0] OP_SUBI = OPCODE_W'(6'b100001);
   localparam logic [OPCODE_W-1:0] OP_LD   = OPCODE_W'(6'b100100);
   localparam logic [OPCODE_W-1:0] OP_ST   = OPCODE_W'(6'b100101);
   localparam logic [OPCODE_W-1:0] OP_BEZ  = OPCODE_W'(6'b101000);
   localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(6'b101001);
   localparam logic [OPCODE_W-1:0] OP_JMP  = OPCODE_W'(6'b101010);

   localparam logic [EXEC_W-1:0] EX_ADD   = EXEC_W'(4'b0000);
   localparam logic [EXEC_W-1:0] EX_SUB   = EXEC_W'(4'b0010);
   localparam logic [EXEC_W-1:0] EX_AND   = EXEC_W'(4'b0100);
   localparam logic [EXEC_W-1:0] EX_OR    = EXEC_W'(4'b0101);
   localparam logic [EXEC_W-1:0] EX_NOR   = EXEC_W'(4'b0110);
   localparam logic [EXEC_W-1:0] EX_XOR   = EXEC_W'(4'b0111);
   localparam logic [EXEC_W-1:0] EX_SHL   = EXEC_W'(4'b1000);
   localparam logic [EXEC_W-1:0] EX_SRA   = EXEC_W'(4'b1001);
   localparam logic [EXEC_W-1:0] EX_SRL   = EXEC_W'(4'b1010);
   localparam logic [EXEC_W-1:0] EX_SEQ0  = EXEC_W'(4'b1100);

   state_e              state_q, state_d;
   logic [STEP_W-1:0]   step_q, step_d;
   logic [STEP_W-1:0]   last_q, last_d;
   logic [EXEC_W-1:0]   exec_cmd_q, exec_cmd_d;
   logic                mem_r_en_q, mem_r_en_d;
   logic                mem_w_en_q, mem_w_en_d;
   logic                wb_en_q, wb_en_d;
   logic                is_imm_q, is_imm_d;
   logic                single_src_q, single_src_d;
   logic [1:0]          branch_type_q, branch_type_d;
   logic                is_seq_q, is_seq_d;
   logic [STEP_W-1:0]   seq_sel_q, seq_sel_d;
   logic                freeze_q, freeze_d;
   logic                illegal_q, illegal_d;

   always_comb begin
      state_d       = S_IDLE;
      step_d        = '0;
      last_d        = last_q;
      exec_cmd_d    = '0;
      mem_r_en_d    = 1'b0;
      mem_w_en_d    = 1'b0;
      wb_en_d       = 1'b0;
      is_imm_d      = 1'b0;
      single_src_d  = 1'b0;
      branch_type_d = 2'b00;
      is_seq_d      = 1'b0;
      seq_sel_d     = '0;
      freeze_d      = 1'b0;
      illegal_d     = 1'b0;

      if (state_q == S_SEQ && step_q != last_q) begin
         // Mid-sequence: opcode/valid_in are ignored, just advance the micro-step.
         state_d    = S_SEQ;
         step_d     = step_q + STEP_W'(1);
         exec_cmd_d = EX_SEQ0 + EXEC_W'(step_d);
         wb_en_d    = 1'b1;
         is_seq_d   = 1'b1;
         seq_sel_d  = step_d + STEP_W'(1);
         freeze_d   = (step_d != last_q);
      end else if (valid_in) begin
         if (opcode == SWP_OPC || opcode == ROT_OPC) begin
            state_d    = S_SEQ;
            step_d     = '0;
            last_d     = (opcode == SWP_OPC) ? STEP_W'(1) : STEP_W'(2);
            exec_cmd_d = EX_SEQ0;
            wb_en_d    = 1'b1;
            is_seq_d   = 1'b1;
            seq_sel_d  = STEP_W'(1);
            freeze_d   = 1'b1;
         end else begin
            case (opcode)
               OP_NOP: ;
               OP_ADD: begin exec_cmd_d = EX_ADD; wb_en_d = 1'b1; end
               OP_SUB: begin exec_cmd_d = EX_SUB; wb_en_d = 1'b1; end
               OP_AND: begin exec_cmd_d = EX_AND; wb_en_d = 1'b1; end
               OP_OR:  begin exec_cmd_d = EX_OR;  wb_en_d = 1'b1; end
               OP_NOR: begin exec_cmd_d = EX_NOR; wb_en_d = 1'b1; end
               OP_XOR: begin exec_cmd_d = EX_XOR; wb_en_d = 1'b1; end
               OP_SLA, OP_SLL: begin exec_cmd_d = EX_SHL; wb_en_d = 1'b1; end
               OP_SRA: begin exec_cmd_d = EX_SRA; wb_en_d = 1'b1; end
               OP_SRL: begin exec_cmd_d = EX_SRL; wb_en_d = 1'b1; end
               OP_ADDI: begin
                  exec_cmd_d   = EX_ADD;
                  wb_en_d      = 1'b1;
                  is_imm_d     = 1'b1;
                  single_src_d = 1'b1;
               end
               OP_SUBI: begin
                  exec_cmd_d   = EX_SUB;
                  wb_en_d      = 1'b1;
                  is_imm_d     = 1'b1;
                  single_src_d = 1'b1;
               end
               OP_LD: begin
                  wb_en_d      = 1'b1;
                  is_imm_d     = 1'b1;
                  single_src_d = 1'b1;
                  mem_r_en_d   = 1'b1;
               end
               OP_ST: begin
                  is_imm_d   = 1'b1;
                  mem_w_en_d = 1'b1;
               end
               OP_BEZ: begin
                  is_imm_d      = 1'b1;
                  single_src_d  = 1'b1;
                  branch_type_d = 2'b01;
               end
               OP_BNE: begin
                  is_imm_d      = 1'b1;
                  branch_type_d = 2'b10;
               end
               OP_JMP: begin
                  is_imm_d      = 1'b1;
                  single_src_d  = 1'b1;
                  branch_type_d = 2'b11;
               end
               default: illegal_d = 1'b1;
            endcase
         end
      end
   end

   // Reset beats stall; stall freezes every register, including the one-cycle illegal flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         step_q        <= '0;
         last_q        <= '0;
         exec_cmd_q    <= '0;
         mem_r_en_q    <= 1'b0;
         mem_w_en_q    <= 1'b0;
         wb_en_q       <= 1'b0;
         is_imm_q      <= 1'b0;
         single_src_q  <= 1'b0;
         branch_type_q <= 2'b00;
         is_seq_q      <= 1'b0;
         seq_sel_q     <= '0;
         freeze_q      <= 1'b0;
         illegal_q     <= 1'b0;
      end else if (!stall) begin
         state_q       <= state_d;
         step_q        <= step_d;
         last_q        <= last_d;
         exec_cmd_q    <= exec_cmd_d;
         mem_r_en_q    <= mem_r_en_d;
         mem_w_en_q    <= mem_w_en_d;
         wb_en_q       <= wb_en_d;
         is_imm_q      <= is_imm_d;
         single_src_q  <= single_src_d;
         branch_type_q <= branch_type_d;
         is_seq_q      <= is_seq_d;
         seq_sel_q     <= seq_sel_d;
         freeze_q      <= freeze_d;
         illegal_q     <= illegal_d;
      end
   end

   assign exec_cmd    = exec_cmd_q;
   assign mem_r_en    = mem_r_en_q;
   assign mem_w_en    = mem_w_en_q;
   assign wb_en       = wb_en_q;
   assign is_imm      = is_imm_q;
   assign single_src  = single_src_q;
   assign branch_type = branch_type_q;
   assign is_seq      = is_seq_q;
   assign seq_sel     = seq_sel_q;
   assign step        = step_q;
   assign freeze      = freeze_q;
   assign illegal     = illegal_q;
   assign state_dbg   = state_q;

endmodule
